ring_step_controller: RTL

//  Sequencer for the one-hot ring-shift datapath (four-stage D-flop ring on the lab board).

---
 rtl/ring_step_pkg.sv | 10 +
 rtl/ring_step_edge.sv | 27 ++
 rtl/ring_step_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ring_step_pkg.sv
// Shared types for the ring-shift sequencer.
package ring_step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } ring_state_t;

endpackage

// File: rtl/ring_step_edge.sv
// Two-flop synchronizer for an asynchronous button level, followed by a rising-edge detector.
module ring_step_edge (
  input  logic hz100,
  input  logic reset,
  input  logic in,
  output logic evt
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge hz100) begin
    if (reset) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign evt = s2_reg & ~s3_reg;

endmodule

// File: rtl/ring_step_controller.sv
// One-hot ring sequencer: single-step from a button or free-run at a prescaled rate,
// with direction control, run/pause/stop and direct position load.
module ring_step_controller
  import ring_step_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int PERIOD = 25,
  localparam int PW     = $clog2(WIDTH)
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
  input  logic             load,
  input  logic [PW-1:0]    load_pos,
  output logic [WIDTH-1:0] ring,
  output logic [PW-1:0]    pos,
  output logic [1:0]       state,
  output logic             wrap
);

  localparam int PCW = $clog2(PERIOD);
  localparam logic [PCW-1:0] PRE_LAST = PCW'(PERIOD - 1);
  localparam logic [PW-1:0]  POS_LAST = PW'(WIDTH - 1);
  localparam logic [PW:0]    POS_LIM  = (PW + 1)'(WIDTH);

  // Event index order: 0 start, 1 stop, 2 step, 3 load
  logic [3:0] ctrl_raw;
  logic [3:0] ctrl_evt;
  assign ctrl_raw = {load, step, stop, start};

  for (genvar gi = 0; gi < 4; gi++) begin : g_edge
    ring_step_edge u_edge (
      .hz100 (hz100),
      .reset (reset),
      .in    (ctrl_raw[gi]),
      .evt   (ctrl_evt[gi])
    );
  end

  logic start_evt;
  logic stop_evt;
  logic step_evt;
  logic load_evt;
  assign start_evt = ctrl_evt[0];
  assign stop_evt  = ctrl_evt[1];
  assign step_evt  = ctrl_evt[2];
  assign load_evt  = ctrl_evt[3];

  logic          dir_s1_reg;
  logic          dir_s2_reg;
  logic [PW-1:0] lp_s1_reg;
  logic [PW-1:0] lp_s2_reg;

  always_ff @(posedge hz100) begin
    if (reset) begin
      dir_s1_reg <= 1'b0;
      dir_s2_reg <= 1'b0;
      lp_s1_reg  <= '0;
      lp_s2_reg  <= '0;
    end else begin
      dir_s1_reg <= dir;
      dir_s2_reg <= dir_s1_reg;
      lp_s1_reg  <= load_pos;
      lp_s2_reg  <= lp_s1_reg;
    end
  end

  ring_state_t    state_reg;
  ring_state_t    state_next;
  logic [PCW-1:0] pre_reg;
  logic [PCW-1:0] pre_next;
  logic           do_load;
  logic           do_adv;

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      pre_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pre_reg   <= pre_next;
    end
  end

  // Only the highest-priority event is acted on; an out-of-range load counts as no load.
  always_comb begin
    state_next = state_reg;
    pre_next   = pre_reg;
    do_load    = 1'b0;
    do_adv     = 1'b0;
    if (load_evt && ({1'b0, lp_s2_reg} < POS_LIM)) begin
      do_load  = 1'b1;
      pre_next = '0;
    end else if (stop_evt) begin
      if (state_reg == ST_RUN) begin
        state_next = ST_PAUSE;
      end else if (state_reg == ST_PAUSE) begin
        state_next = ST_IDLE;
        pre_next   = '0;
      end
    end else if (start_evt && (state_reg != ST_RUN)) begin
      state_next = ST_RUN;
      if (state_reg == ST_IDLE) begin
        pre_next = '0;
      end
    end else if (step_evt && (state_reg != ST_RUN)) begin
      do_adv = 1'b1;
    end else if (state_reg == ST_RUN) begin
      if (pre_reg == PRE_LAST) begin
        do_adv   = 1'b1;
        pre_next = '0;
      end else begin
        pre_next = pre_reg + PCW'(1);
      end
    end
  end

  function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] r, input logic d);
    rotate = d ? {r[0], r[WIDTH-1:1]} : {r[WIDTH-2:0], r[WIDTH-1]};
  endfunction

  logic [WIDTH-1:0] ring_reg;
  logic [PW-1:0]    pos_reg;
  logic             wrap_reg;
  logic [PW-1:0]    pos_adv;

  always_comb begin
    pos_adv = pos_reg + PW'(1);
    if (dir_s2_reg) begin
      pos_adv = (pos_reg == '0) ? POS_LAST : pos_reg - PW'(1);
    end else if (pos_reg == POS_LAST) begin
      pos_adv = '0;
    end
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      ring_reg <= WIDTH'(1);
      pos_reg  <= '0;
      wrap_reg <= 1'b0;
    end else if (!$onehot(ring_reg)) begin
      // Recover from a corrupted ring without disturbing the FSM
      ring_reg <= WIDTH'(1);
      pos_reg  <= '0;
      wrap_reg <= 1'b0;
    end else if (do_load) begin
      ring_reg <= WIDTH'(1) << lp_s2_reg;
      pos_reg  <= lp_s2_reg;
      wrap_reg <= 1'b0;
    end else if (do_adv) begin
      ring_reg <= rotate(ring_reg, dir_s2_reg);
      pos_reg  <= pos_adv;
      wrap_reg <= dir_s2_reg ? ring_reg[0] : ring_reg[WIDTH-1];
    end else begin
      wrap_reg <= 1'b0;
    end
  end

  assign ring  = ring_reg;
  assign pos   = pos_reg;
  assign state = state_reg;
  assign wrap  = wrap_reg;

endmodule
